hub_port: RTL and testbench
===========================

Name: hub_port

Overview:
- Cog-side hub access sequencer, directly upstream of the hub.
- Accepts one hub request (rdbyte/word/long, wrbyte/word/long, sys op) from the cog core.
- Drives the cog's bus_* lines only during the cog's own hub slot, waits for the rotated acknowledge two slots later, then returns read data and carry to the core.
- One instance per cog. The hub ORs all instances' bus outputs, so an idle or unselected port must drive zeros.

Parameters:
- TIMEOUT_SLOTS, 32: ena_bus strobes allowed from acceptance to acknowledge before abort. Used only with HUB_PORT_TIMEOUT_EN.

Ports:
- clk_cog  in  1  system clock
- nres  in  1  asynchronous active-low reset
- ena_bus  in  1  hub slot strobe; one clk_cog cycle per hub slot
- sel  in  1  this cog's bus_sel bit; 1 = current slot belongs to this cog
- ack  in  1  this cog's bus_ack bit from the hub
- bus_q  in  32  hub read data
- bus_c  in  1  hub carry (sys ops)
- req  in  1  request valid; fields below must be stable while req=1 and ready=1
- req_w  in  1  1 = write
- req_r  in  1  0 with req_a[15]=1 selects ROM unscramble (cog load); normally 1
- req_s  in  2  00 byte, 01 word, 10 long, 11 sys
- req_a  in  16  byte address, or sys op code in [2:0]
- req_d  in  32  write data / sys operand
- ready  out  1  1 in IDLE; request accepted on the edge where req && ready
- done  out  1  one-cycle pulse when the response is valid
- rsp_q  out  32  captured bus_q; held until the next done
- rsp_c  out  1  captured bus_c; held until the next done
- err  out  1  timeout flag, valid with done; tied 0 without the macro
- bus_r, bus_e, bus_w  out  1 each  to hub
- bus_s  out  2  to hub
- bus_a  out  16  to hub
- bus_d  out  32  to hub

Behaviour:
- Reset (async, nres=0):
  - state IDLE.
  - ready=1; done=0; err=0; rsp_q=0; rsp_c=0.
  - All bus_* outputs 0.
  - Timeout counter 0.
- State machine:
  - IDLE -> WAIT_SLOT on req && ready. req_w, req_r, req_s, req_a and req_d are registered into a request latch.
  - WAIT_SLOT: bus outputs are the latched fields with bus_e=1, driven combinationally only while sel=1; otherwise every bus_* output is 0. On ena_bus && sel -> WAIT_ACK.
  - WAIT_ACK: bus outputs are 0. On ena_bus && ack -> RESP; capture rsp_q<=bus_q and rsp_c<=bus_c on the same edge.
  - RESP: done=1 for exactly one cycle -> IDLE.
- A request accepted in the same cycle as ena_bus && sel is not presented in that slot. It waits for the cog's next slot; no combinational req-to-bus path.
- An ack arriving while in WAIT_SLOT or IDLE is ignored; no done is produced.
- Writes complete identically to reads: done pulses and rsp_q captures whatever bus_q shows. The core must ignore rsp_q for writes.
- Latency from accept to done:
  - Minimum: one slot wait, plus two slots to ack, plus 1 clk_cog.
  - Maximum: 8 slots wait, plus two slots, plus 1 clk_cog.
- ready=0 in WAIT_SLOT, WAIT_ACK and RESP. A new request is accepted at the earliest one cycle after done.
- rsp_q, rsp_c and err hold their values until the next capture.
- Reset asserted mid-operation aborts immediately. No done is produced, and bus outputs go to 0 asynchronously.

Optional Feature:
- Macro HUB_PORT_TIMEOUT_EN.
- Defined:
  - A counter clears on acceptance and increments on each ena_bus in WAIT_SLOT or WAIT_ACK.
  - When the count reaches TIMEOUT_SLOTS without ack -> RESP with err=1, rsp_q=0, rsp_c=0.
  - err clears to 0 on the next normal completion.
- Not defined: no counter exists, err is constant 0, and the port waits indefinitely.

Test Plan:
- rdlong, a=16'h0100: sel pulses every 8th ena_bus, and the bench returns ack two slots after the cog's slot with bus_q=32'hDEADBEEF.
  - Required: bus_e=1, bus_s=10, bus_a=16'h0100 only during the sel slot.
  - Required: done pulses once; rsp_q=32'hDEADBEEF; ready returns to 1 the next cycle.
- wrword a=16'h0002, d=32'h0000ABCD: bus_w=1, bus_s=01, bus_d=32'h0000ABCD during the slot and all zeros outside it. done follows the ack.
- Sys op (s=11, a=3'b100 locknew): bench returns bus_q=3, bus_c=1 -> rsp_q=32'h3, rsp_c=1.
- req asserted in the same cycle as the cog's slot: no bus_e in that slot; the request is issued in the next slot 8 strobes later.
- nres pulsed low while in WAIT_ACK: bus outputs 0 immediately, no done, ready=1, and rsp_q=0 after release.
- HUB_PORT_TIMEOUT_EN defined, TIMEOUT_SLOTS=32, ack never given: done with err=1 after the 32nd ena_bus; the next request that is acked completes with err=0.

Source files
------------

// File: rtl/hub_port_if.sv
// hub_port_if: request/response and hub-bus signal bundle for one cog's hub port
// Ports (via modports):
//   slave  - hub_port side: takes hub strobes/ack/data and core requests, drives bus_* and responses
//   master - environment side (core + hub): the mirror image of slave
interface hub_port_if;
    logic        ena_bus;
    logic        sel;
    logic        ack;
    logic [31:0] bus_q;
    logic        bus_c;
    logic        req;
    logic        req_w;
    logic        req_r;
    logic [1:0]  req_s;
    logic [15:0] req_a;
    logic [31:0] req_d;
    logic        ready;
    logic        done;
    logic [31:0] rsp_q;
    logic        rsp_c;
    logic        err;
    logic        bus_r;
    logic        bus_e;
    logic        bus_w;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d;

    modport slave (
        input  ena_bus, sel, ack, bus_q, bus_c, req, req_w, req_r, req_s, req_a, req_d,
        output ready, done, rsp_q, rsp_c, err, bus_r, bus_e, bus_w, bus_s, bus_a, bus_d
    );

    modport master (
        output ena_bus, sel, ack, bus_q, bus_c, req, req_w, req_r, req_s, req_a, req_d,
        input  ready, done, rsp_q, rsp_c, err, bus_r, bus_e, bus_w, bus_s, bus_a, bus_d
    );
endinterface

// File: rtl/hub_port.sv
// hub_port: cog-side hub access sequencer; presents one latched request in the cog's own slot
// Ports:
//   clk_cog - system clock
//   nres    - asynchronous active-low reset
//   hif     - hub_port_if.slave: core request/response and hub bus signals
// Optional macro HUB_PORT_TIMEOUT_EN: abort with err=1 after TIMEOUT_SLOTS slot strobes without ack.
module hub_port
`ifdef HUB_PORT_TIMEOUT_EN
#(
    parameter int TIMEOUT_SLOTS = 32
)
`endif
(
    input  logic       clk_cog,
    input  logic       nres,
    hub_port_if.slave  hif
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_SLOT = 2'd1;
    localparam logic [1:0] WAIT_ACK  = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    logic [1:0]  r_state;
    logic        r_w;
    logic        r_r;
    logic [1:0]  r_s;
    logic [15:0] r_a;
    logic [31:0] r_d;
    logic [31:0] r_q;
    logic        r_c;
    logic        w_drive;
    logic        w_slot;
    logic        w_ack;
    logic        w_to;

    // The hub ORs every cog's outputs, so drive only inside our own slot
    assign w_drive = (r_state == WAIT_SLOT) && hif.sel;
    assign w_slot  = w_drive && hif.ena_bus;
    assign w_ack   = (r_state == WAIT_ACK) && hif.ena_bus && hif.ack;

`ifdef HUB_PORT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_SLOTS + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_busy;

    assign w_busy = (r_state == WAIT_SLOT) || (r_state == WAIT_ACK);
    // Fires on the strobe that would bring the count to TIMEOUT_SLOTS; a real ack on it wins
    assign w_to   = w_busy && hif.ena_bus && !w_ack && (r_cnt == CW'(TIMEOUT_SLOTS - 1));
    assign hif.err = r_err;

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == IDLE) ? '0 : (w_busy && hif.ena_bus) ? r_cnt + 1'b1 : r_cnt;
            r_err <= w_to ? 1'b1 : w_ack ? 1'b0 : r_err;
        end
    end
`else
    assign w_to    = 1'b0;
    assign hif.err = 1'b0;
`endif

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            r_state <= IDLE;
            r_w     <= 1'b0;
            r_r     <= 1'b0;
            r_s     <= 2'b00;
            r_a     <= 16'h0000;
            r_d     <= 32'h0;
            r_q     <= 32'h0;
            r_c     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (hif.req) begin
                        r_state <= WAIT_SLOT;
                        r_w     <= hif.req_w;
                        r_r     <= hif.req_r;
                        r_s     <= hif.req_s;
                        r_a     <= hif.req_a;
                        r_d     <= hif.req_d;
                    end
                end
                WAIT_SLOT: r_state <= w_to ? RESP : w_slot ? WAIT_ACK : WAIT_SLOT;
                WAIT_ACK:  r_state <= (w_to || w_ack) ? RESP : WAIT_ACK;
                default:   r_state <= IDLE;
            endcase
            if (w_ack) begin
                r_q <= hif.bus_q;
                r_c <= hif.bus_c;
            end else if (w_to) begin
                r_q <= 32'h0;
                r_c <= 1'b0;
            end
        end
    end

    assign hif.ready = (r_state == IDLE);
    assign hif.done  = (r_state == RESP);
    assign hif.rsp_q = r_q;
    assign hif.rsp_c = r_c;
    assign hif.bus_e = w_drive;
    assign hif.bus_r = w_drive & r_r;
    assign hif.bus_w = w_drive & r_w;
    assign hif.bus_s = w_drive ? r_s : 2'b00;
    assign hif.bus_a = w_drive ? r_a : 16'h0000;
    assign hif.bus_d = w_drive ? r_d : 32'h0;
endmodule

// File: tb/tb_hub_port.sv
// tb_hub_port: directed scoreboard bench for hub_port with a small 8-slot hub model
module tb_hub_port;
    logic clk_cog = 1'b0;
    logic nres    = 1'b0;
    always #5 clk_cog = ~clk_cog;

    hub_port_if hif();
    hub_port u_dut (.clk_cog(clk_cog), .nres(nres), .hif(hif));

    typedef struct {
        logic [31:0] q;
        logic        c;
        logic        e;
    } rsp_t;
    rsp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Hub model: one slot per two clocks, strobe on the second; slot 0 belongs to this cog
    logic [7:0]  tick       = 8'd0;
    logic        ack_pend   = 1'b0;
    logic [2:0]  ack_slot   = 3'd0;
    logic        hub_ack_en = 1'b1;
    logic        stray_ack  = 1'b0;
    logic [31:0] hub_q      = 32'h0;
    logic        hub_c      = 1'b0;
    wire  [2:0]  slot       = tick[3:1];

    always @(negedge clk_cog) tick <= tick + 8'd1;
    assign hif.ena_bus = tick[0];
    assign hif.sel     = (slot == 3'd0);
    assign hif.ack     = (ack_pend && slot == ack_slot && hub_ack_en) || stray_ack;
    assign hif.bus_q   = hif.ack ? hub_q : 32'h5555_5555;
    assign hif.bus_c   = hif.ack & hub_c;

    always @(posedge clk_cog) begin
        if (hif.ena_bus && hif.sel && hif.bus_e) begin
            ack_pend <= 1'b1;
            ack_slot <= slot + 3'd2;
        end else if (hif.ena_bus && hif.ack) begin
            ack_pend <= 1'b0;
        end
    end

    logic        e_w, e_r;
    logic [1:0]  e_s;
    logic [15:0] e_a;
    logic [31:0] e_d;
    int          w_strobes, t_strobes, n_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_cog);
        #1;
    endtask

    task automatic accept(input logic w, input logic r, input logic [1:0] s, input logic [15:0] a,
                          input logic [31:0] d, input logic [31:0] eq, input logic ec, input logic ee);
        chk("ready_idle", hif.ready, 1);
        hif.req = 1'b1; hif.req_w = w; hif.req_r = r; hif.req_s = s; hif.req_a = a; hif.req_d = d;
        e_w = w; e_r = r; e_s = s; e_a = a; e_d = d;
        sb.push_back('{eq, ec, ee});
        step();
        hif.req = 1'b0; hif.req_w = ~w; hif.req_r = ~r; hif.req_s = ~s; hif.req_a = ~a; hif.req_d = ~d;
        chk("ready_busy", hif.ready, 0);
    endtask

    task automatic run(input logic stray, output int wait_n, output int total_n);
        logic phase = 1'b0;
        rsp_t r;
        wait_n  = 0;
        total_n = 0;
        for (int n = 0; n < 400 && !hif.done; n++) begin
            stray_ack = stray && !phase;
            chk("bus", {hif.bus_e, hif.bus_r, hif.bus_w, hif.bus_s, hif.bus_a, hif.bus_d},
                (!phase && hif.sel) ? {1'b1, e_r, e_w, e_s, e_a, e_d} : 64'h0);
            if (hif.ena_bus) total_n++;
            if (hif.ena_bus && !phase) wait_n++;
            if (hif.ena_bus && hif.sel && !phase) phase = 1'b1;
            step();
        end
        stray_ack = 1'b0;
        chk("done_seen", hif.done, 1);
        chk("done_after_slot", phase, 1);
        if (hif.done && sb.size() > 0) begin
            r = sb.pop_front();
            chk("rsp_q", hif.rsp_q, r.q);
            chk("rsp_c", hif.rsp_c, r.c);
            chk("err", hif.err, r.e);
        end
        step();
        chk("done_one_cycle", hif.done, 0);
        chk("ready_back", hif.ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        hif.req = 1'b0; hif.req_w = 1'b0; hif.req_r = 1'b0; hif.req_s = 2'b00;
        hif.req_a = 16'h0; hif.req_d = 32'h0;
        repeat (3) step();
        chk("rst_ready", hif.ready, 1);
        chk("rst_done", hif.done, 0);
        chk("rst_err", hif.err, 0);
        chk("rst_rsp", {hif.rsp_c, hif.rsp_q}, 0);
        chk("rst_bus", {hif.bus_e, hif.bus_r, hif.bus_w, hif.bus_s, hif.bus_a, hif.bus_d}, 0);
        nres = 1'b1;
        repeat (3) step();

        hub_q = 32'hDEAD_BEEF; hub_c = 1'b0;
        accept(1'b0, 1'b1, 2'b10, 16'h0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run(1'b0, w_strobes, t_strobes);
        chk("rdlong_wait_range", (w_strobes >= 1 && w_strobes <= 8), 1);
        chk("rdlong_ack_2_slots", t_strobes, w_strobes + 2);
        repeat (5) step();
        chk("rsp_hold", hif.rsp_q, 32'hDEAD_BEEF);

        hub_q = 32'h0000_1234; hub_c = 1'b0;
        accept(1'b1, 1'b1, 2'b01, 16'h0002, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 1'b0);
        run(1'b0, w_strobes, t_strobes);

        hub_q = 32'h3; hub_c = 1'b1;
        accept(1'b0, 1'b1, 2'b11, 16'h0004, 32'h0, 32'h3, 1'b1, 1'b0);
        run(1'b1, w_strobes, t_strobes);

        hub_q = 32'hCAFE_0001; hub_c = 1'b0;
        for (int n = 0; n < 32 && !(hif.ena_bus && hif.sel); n++) step();
        chk("same_slot_bus_e_idle", hif.bus_e, 0);
        accept(1'b0, 1'b1, 2'b00, 16'h0005, 32'h0, 32'hCAFE_0001, 1'b0, 1'b0);
        run(1'b0, w_strobes, t_strobes);
        chk("same_slot_next_8", w_strobes, 8);

        hub_q = 32'h7777_7777; hub_c = 1'b1;
        accept(1'b0, 1'b1, 2'b10, 16'h0010, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int n = 0; n < 100 && !(hif.ena_bus && hif.sel && hif.bus_e); n++) step();
        step();
        nres = 1'b0;
        #1;
        sb.delete();
        chk("abort_ready", hif.ready, 1);
        chk("abort_done", hif.done, 0);
        chk("abort_rsp", {hif.rsp_c, hif.rsp_q}, 0);
        chk("abort_bus", {hif.bus_e, hif.bus_r, hif.bus_w, hif.bus_s, hif.bus_a, hif.bus_d}, 0);
        step();
        nres = 1'b1;
        n_done = 0;
        for (int n = 0; n < 24; n++) begin
            if (hif.done) n_done++;
            step();
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_rsp_after", hif.rsp_q, 0);

        hub_q = 32'h0000_BEEF; hub_c = 1'b0;
        accept(1'b0, 1'b1, 2'b01, 16'h0020, 32'h0, 32'h0000_BEEF, 1'b0, 1'b0);
        run(1'b0, w_strobes, t_strobes);

`ifdef HUB_PORT_TIMEOUT_EN
        hub_ack_en = 1'b0;
        accept(1'b0, 1'b1, 2'b10, 16'h0200, 32'h0, 32'h0, 1'b0, 1'b1);
        run(1'b0, w_strobes, t_strobes);
        chk("timeout_32_strobes", t_strobes, 32);
        hub_ack_en = 1'b1;
        hub_q = 32'h1357_9BDF; hub_c = 1'b1;
        accept(1'b0, 1'b1, 2'b10, 16'h0204, 32'h0, 32'h1357_9BDF, 1'b1, 1'b0);
        run(1'b0, w_strobes, t_strobes);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
